word_render: RTL

//  Reader side of the 64x32 word-glyph ROMs. It sits between the VGA sync generator and
//  the RGB mux. It turns the current pixel coordinate into a ROM row address, samples
//  the returned 64-bit row and selects the bit for that pixel. It emits a pixel-aligned

---
 rtl/word_render.sv | 128 ++++++++++++
 1 files changed

// File: rtl/word_render.sv
// word_render: reader side of the 64x32 word-glyph ROM.
// Two-stage pixel pipeline. Stage 1 turns the pixel coordinate into a ROM row address
// and a glyph column. Stage 2 picks the glyph bit from the returned ROM row.
// Sync and video_on are delayed two ticks so they stay aligned with word_on/rgb_out.
// Optional feature: define WORD_BLINK_EN to blink the word every BLINK_FRAMES frames.
module word_render #(
  parameter int          SCALE_LOG2   = 1,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  org_x,
  input  logic [9:0]  org_y,
  output logic [4:0]  drom_addr_num,
  input  logic [0:63] drom_data_num,
  output logic        word_on,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        video_on_out
);

  localparam logic [10:0] BOX_W = 11'(64 << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(32 << SCALE_LOG2);

  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic        in_box_s;
  logic [5:0]  col_s;
  logic [4:0]  row_s;
  logic        bit_s;
  logic        show_s;
  logic        word_next_s;

  logic [5:0]  col_r;
  logic        in_box_r;
  logic        video_d1_r;
  logic        hsync_d1_r;
  logic        vsync_d1_r;

  // Stage-1 geometry: offset inside the box, box test and scaled glyph coordinates
  always_comb begin
    dx_s     = {1'b0, pixel_x} - {1'b0, org_x};
    dy_s     = {1'b0, pixel_y} - {1'b0, org_y};
    in_box_s = (pixel_x >= org_x) && (dx_s < BOX_W) &&
               (pixel_y >= org_y) && (dy_s < BOX_H);
    col_s    = 6'(dx_s >> SCALE_LOG2);
    row_s    = 5'(dy_s >> SCALE_LOG2);
  end

  // Stage-1 registers; the ROM address is parked at row 0 outside the box.
  // Sync stages reset to the inactive (high) level so no false sync pulse leaves the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_r         <= 6'd0;
      in_box_r      <= 1'b0;
      drom_addr_num <= 5'd0;
      video_d1_r    <= 1'b0;
      hsync_d1_r    <= 1'b1;
      vsync_d1_r    <= 1'b1;
    end else if (pixel_tick) begin
      col_r         <= in_box_s ? col_s : 6'd0;
      in_box_r      <= in_box_s;
      drom_addr_num <= in_box_s ? row_s : 5'd0;
      video_d1_r    <= video_on;
      hsync_d1_r    <= hsync_in;
      vsync_d1_r    <= vsync_in;
    end
  end

`ifdef WORD_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] frame_cnt_r;
  logic          show_r;

  // Frame counter on vsync falling edges (vsync_d1_r is the previous ticked vsync);
  // the shown/hidden phase flips each time the counter wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= '0;
      show_r      <= 1'b1;
    end else if (pixel_tick && vsync_d1_r && !vsync_in) begin
      if (frame_cnt_r == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt_r <= '0;
        show_r      <= ~show_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + CW'(1);
      end
    end
  end

  assign show_s = show_r;
`else
  assign show_s = 1'b1;
`endif

  // Stage-2 bit select from the ROM row (index 0 is the leftmost glyph column)
  always_comb begin
    bit_s       = drom_data_num[col_r];
    word_next_s = in_box_r & video_d1_r & bit_s & show_s;
  end

  // Stage-2 output registers, advanced only on pixel ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_on      <= 1'b0;
      rgb_out      <= 12'h000;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
    end else if (pixel_tick) begin
      word_on      <= word_next_s;
      rgb_out      <= word_next_s ? FG_COLOR : 12'h000;
      video_on_out <= video_d1_r;
      hsync_out    <= hsync_d1_r;
      vsync_out    <= vsync_d1_r;
    end
  end

endmodule
